memory_game_ctrl: RTL

MEMORY_GAME_CTRL -- requirements
Module: memory_game_ctrl

---
 rtl/memory_game_ctrl_if.sv | 30 +++
 rtl/memory_game_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/memory_game_ctrl_if.sv
// memory_game_ctrl_if: board-side signal bundle for the memory game controller.
// The game controller sits on the slave side; the board/buttons side is the master.
interface memory_game_ctrl_if #(
  parameter int COLS = 5,
  parameter int ROWS = 4
);
  localparam int N  = COLS * ROWS;
  localparam int IW = $clog2(N);
  localparam int PW = $clog2(N / 2 + 1);
  logic [N*IW-1:0] deck;
  logic            move_x;
  logic            move_y;
  logic            select;
  logic            restart;
  logic [IW-1:0]   cursor;
  logic [N-1:0]    face_up;
  logic [N-1:0]    matched;
  logic [PW-1:0]   pairs;
  logic [15:0]     attempts;
  logic            busy;
  logic            game_done;
  modport slave (
    input  deck, move_x, move_y, select, restart,
    output cursor, face_up, matched, pairs, attempts, busy, game_done
  );
  modport master (
    output deck, move_x, move_y, select, restart,
    input  cursor, face_up, matched, pairs, attempts, busy, game_done
  );
endinterface

// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl: pick-two-cards memory game with cursor navigation,
// pair matching, mismatch hold timer, and attempt/pair bookkeeping.
module memory_game_ctrl #(
  parameter int COLS        = 5,
  parameter int ROWS        = 4,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic               clock_50M,
  input  logic               reset_n,
  memory_game_ctrl_if.slave  bus
);
  localparam int N  = COLS * ROWS;
  localparam int IW = $clog2(N);
  localparam int PW = $clog2(N / 2 + 1);
  localparam int TW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;

  if (N < 2 || N % 2 != 0) begin : g_bad_board
    $error("memory_game_ctrl: COLS*ROWS must be even and at least 2");
  end

  typedef enum logic [2:0] {PICK1, PICK2, COMPARE, HOLD, DONE} state_t;

  state_t          r_state, w_state;
  logic [3:0]      r_s1, r_s2, r_prev, w_fire;
  logic [2:0]      r_live;
  logic [IW-1:0]   r_col, r_row, r_first, r_second;
  logic [IW-1:0]   w_col, w_row, w_first, w_second, w_pos, w_id1, w_id2;
  logic [N-1:0]    r_face, r_matched, w_face, w_matched;
  logic [PW-1:0]   r_pairs, w_pairs;
  logic [15:0]     r_att, w_att;
  logic [TW-1:0]   r_timer, w_timer;

  // r_live masks edges until the synchroniser holds post-reset samples, so a
  // button held through reset release never looks like a fresh press
  assign w_fire = r_s2 & ~r_prev & {4{r_live[2]}};
  assign w_pos  = IW'(r_col * ROWS + r_row);
  assign w_id1  = bus.deck[r_first * IW +: IW];
  assign w_id2  = bus.deck[r_second * IW +: IW];

  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
      r_live <= '0;
    end else begin
      r_s1   <= {bus.restart, bus.select, bus.move_y, bus.move_x};
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_live <= {r_live[1:0], 1'b1};
    end
  end

  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= PICK1;
      r_col     <= '0;
      r_row     <= '0;
      r_first   <= '0;
      r_second  <= '0;
      r_face    <= '0;
      r_matched <= '0;
      r_pairs   <= '0;
      r_att     <= '0;
      r_timer   <= '0;
    end else begin
      r_state   <= w_state;
      r_col     <= w_col;
      r_row     <= w_row;
      r_first   <= w_first;
      r_second  <= w_second;
      r_face    <= w_face;
      r_matched <= w_matched;
      r_pairs   <= w_pairs;
      r_att     <= w_att;
      r_timer   <= w_timer;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_col     = r_col;
    w_row     = r_row;
    w_first   = r_first;
    w_second  = r_second;
    w_face    = r_face;
    w_matched = r_matched;
    w_pairs   = r_pairs;
    w_att     = r_att;
    w_timer   = r_timer;
    if (w_fire[3]) begin
      w_state   = PICK1;
      w_col     = '0;
      w_row     = '0;
      w_face    = '0;
      w_matched = '0;
      w_pairs   = '0;
      w_att     = '0;
      w_timer   = '0;
    end else begin
      if (r_state != DONE) begin
        if (w_fire[0]) w_col = r_col == '0 ? IW'(COLS - 1) : r_col - 1'b1;
        if (w_fire[1]) w_row = r_row == IW'(ROWS - 1) ? '0 : r_row + 1'b1;
      end
      // selects use w_pos, the cursor before any same-cycle move
      case (r_state)
        PICK1: if (w_fire[2] && !r_face[w_pos]) begin
          w_first       = w_pos;
          w_face[w_pos] = 1'b1;
          w_state       = PICK2;
        end
        PICK2: if (w_fire[2] && !r_face[w_pos]) begin
          w_second      = w_pos;
          w_face[w_pos] = 1'b1;
          w_state       = COMPARE;
          w_att         = r_att + {15'd0, r_att != 16'hFFFF};
        end
        COMPARE: if ((w_id1 >> 1) == (w_id2 >> 1)) begin
          w_matched[r_first]  = 1'b1;
          w_matched[r_second] = 1'b1;
          w_pairs             = r_pairs + 1'b1;
          w_state             = int'(r_pairs) + 1 == N / 2 ? DONE : PICK1;
        end else begin
          w_timer = TW'(HOLD_CYCLES - 1);
          w_state = HOLD;
        end
        HOLD: if (r_timer == '0) begin
          w_face[r_first]  = 1'b0;
          w_face[r_second] = 1'b0;
          w_state          = PICK1;
        end else begin
          w_timer = r_timer - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.cursor    = w_pos;
  assign bus.face_up   = r_face;
  assign bus.matched   = r_matched;
  assign bus.pairs     = r_pairs;
  assign bus.attempts  = r_att;
  assign bus.busy      = r_state == COMPARE || r_state == HOLD;
  assign bus.game_done = r_state == DONE;
endmodule
